// File: rtl/ddfs_phase_accumulator_if.sv
// Control and sample bus of the DDFS phase accumulator.
// The master drives the run and frequency controls; the slave returns the table address and strobes.
interface ddfs_phase_accumulator_if;
    logic       enable;
    logic [6:0] fw;
    logic [2:0] freq_control;
    logic       mirror_x;
    logic       mirror_y;
    logic [9:0] phase_addr;
    logic       invert;
    logic       sample_valid;
    logic       period_start;

    modport master (
        output enable, fw, freq_control, mirror_x, mirror_y,
        input  phase_addr, invert, sample_valid, period_start
    );

    modport slave (
        input  enable, fw, freq_control, mirror_x, mirror_y,
        output phase_addr, invert, sample_valid, period_start
    );
endinterface

// File: rtl/ddfs_phase_accumulator.sv
// Prescaled 10-bit phase accumulator with quarter/half-wave segment folding for a DDFS.
// Define DDFS_SYNC_UPDATE_EN to defer control changes to output-period boundaries.
module ddfs_phase_accumulator (
    input  logic                           clk,
    input  logic                           rst_n,
    ddfs_phase_accumulator_if.slave        bus
);

    logic [19:0] cnt;
    logic [9:0]  acc;
    logic [1:0]  seg;
    logic [6:0]  fw_sh;
    logic [2:0]  fc_sh;
    logic        mx_sh;
    logic        my_sh;
    logic        sv_q;
    logic        ps_q;

    logic [19:0] div_m1;
    logic        tick;
    logic [10:0] sum;
    logic        carry;
    logic [1:0]  seg_mask;
    logic [1:0]  seg_nxt;
    logic        wrap;
    logic        shadow_load;
    logic        fc_change;

    always_comb begin
        div_m1 = 20'd1;
        case (fc_sh)
            3'd0:    div_m1 = 20'd1;
            3'd1:    div_m1 = 20'd9;
            3'd2:    div_m1 = 20'd99;
            3'd3:    div_m1 = 20'd999;
            3'd4:    div_m1 = 20'd9999;
            3'd5:    div_m1 = 20'd99999;
            3'd6:    div_m1 = 20'd999999;
            default: div_m1 = 20'd1;
        endcase
    end

    assign tick  = bus.enable && (cnt == div_m1);
    assign sum   = {1'b0, acc} + {4'b0000, fw_sh} + 11'd1;
    assign carry = sum[10];

    // Segment count is 1, 2 or 4, so wrapping reduces to masking the incremented value.
    assign seg_mask = {mx_sh & my_sh, mx_sh | my_sh};
    assign seg_nxt  = (seg + 2'd1) & seg_mask;
    assign wrap     = tick && carry && (seg_nxt == 2'd0);

`ifdef DDFS_SYNC_UPDATE_EN
    assign shadow_load = !bus.enable || wrap;
`else
    assign shadow_load = 1'b1;
`endif

    assign fc_change = shadow_load && (bus.freq_control != fc_sh);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= 20'd0;
            acc   <= 10'd0;
            seg   <= 2'd0;
            fw_sh <= 7'd0;
            fc_sh <= 3'd0;
            mx_sh <= 1'b0;
            my_sh <= 1'b0;
            sv_q  <= 1'b0;
            ps_q  <= 1'b0;
        end else begin
            sv_q <= tick;
            ps_q <= wrap;

            if (!bus.enable || tick || fc_change) begin
                cnt <= 20'd0;
            end else begin
                cnt <= cnt + 20'd1;
            end

            if (tick) begin
                acc <= sum[9:0];
                if (carry) begin
                    seg <= seg_nxt;
                end
            end

            if (shadow_load) begin
                fw_sh <= bus.fw;
                fc_sh <= bus.freq_control;
                mx_sh <= bus.mirror_x;
                my_sh <= bus.mirror_y;
            end
        end
    end

    // Odd segments run backwards through the table when time-mirrored.
    assign bus.phase_addr   = (mx_sh && seg[0]) ? ~acc : acc;
    assign bus.invert       = my_sh && (mx_sh ? seg[1] : seg[0]);
    assign bus.sample_valid = sv_q;
    assign bus.period_start = ps_q;

endmodule

// File: tb/tb_ddfs_phase_accumulator.sv
// Scoreboard bench for ddfs_phase_accumulator: a tick-level phase model queues expected samples,
// a monitor compares every sample_valid pulse against the queue.
module tb_ddfs_phase_accumulator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ddfs_phase_accumulator_if bus ();

    ddfs_phase_accumulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef DDFS_SYNC_UPDATE_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    typedef struct {
        int cyc;
        int addr;
        int inv;
        int ps;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference state: phase, segment and the control values currently in effect.
    int m_acc, m_seg, m_fw, m_fc, m_mx, m_my, m_n;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int div_of(input int fc);
        case (fc)
            0: return 2;
            1: return 10;
            2: return 100;
            3: return 1000;
            4: return 10000;
            5: return 100000;
            6: return 1000000;
            default: return 2;
        endcase
    endfunction

    // Predict the effect of the upcoming rising edge, then advance to 2 ns after it.
    task automatic cycle();
        int   tick, carry, ps, load, s, nseg;
        exp_t e;
        tick = 0;
        ps   = 0;
        if (rst_n !== 1'b1) begin
            m_acc = 0; m_seg = 0; m_fw = 0; m_fc = 0; m_mx = 0; m_my = 0; m_n = 0;
        end else begin
            if (bus.enable) begin
                tick = (((m_n + 1) % div_of(m_fc)) == 0) ? 1 : 0;
                m_n  = m_n + 1;
                if (tick != 0) begin
                    s     = m_acc + m_fw + 1;
                    carry = (s >= 1024) ? 1 : 0;
                    m_acc = s % 1024;
                    if (carry != 0) begin
                        nseg  = (m_mx != 0 && m_my != 0) ? 4 : ((m_mx != 0 || m_my != 0) ? 2 : 1);
                        m_seg = (m_seg + 1) % nseg;
                        ps    = (m_seg == 0) ? 1 : 0;
                    end
                end
            end else begin
                m_n = 0;
            end
            load = (!bus.enable || !SYNC || (tick != 0 && ps != 0)) ? 1 : 0;
            if (load != 0) begin
                if (int'(bus.freq_control) != m_fc) m_n = 0;
                m_fw = int'(bus.fw);
                m_fc = int'(bus.freq_control);
                m_mx = int'(bus.mirror_x);
                m_my = int'(bus.mirror_y);
            end
            if (tick != 0) begin
                e.cyc  = cyc + 1;
                e.addr = (m_mx != 0 && (m_seg % 2) == 1) ? 1023 - m_acc : m_acc;
                e.inv  = (m_my != 0 && (m_mx != 0 ? (m_seg >= 2) : ((m_seg % 2) == 1))) ? 1 : 0;
                e.ps   = ps;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic setup(input int fc, input int fw, input int mx, input int my);
        bus.enable       = 1'b0;
        bus.freq_control = 3'(fc);
        bus.fw           = 7'(fw);
        bus.mirror_x     = mx[0];
        bus.mirror_y     = my[0];
        cycle();
        cycle();
        bus.enable = 1'b1;
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if (bus.phase_addr !== 10'd0 || bus.invert !== 1'b0 ||
            bus.sample_valid !== 1'b0 || bus.period_start !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got addr=%0d inv=%0b sv=%0b ps=%0b, want all 0",
                     name, bus.phase_addr, bus.invert, bus.sample_valid, bus.period_start);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.sample_valid === 1'b1) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_sample cyc=%0d addr=%0d: no sample expected", cyc, bus.phase_addr);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || int'(bus.phase_addr) != e.addr ||
                        int'(bus.invert) != e.inv || int'(bus.period_start) != e.ps) begin
                        n_err++;
                        $display("FAIL sample: got cyc=%0d addr=%0d inv=%0d ps=%0d, want cyc=%0d addr=%0d inv=%0d ps=%0d",
                                 cyc, bus.phase_addr, bus.invert, bus.period_start,
                                 e.cyc, e.addr, e.inv, e.ps);
                    end
                end
            end else begin
                if (bus.period_start === 1'b1) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL period_start_alone cyc=%0d: got 1, want 0 without sample_valid", cyc);
                end
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL missing_sample: got none at cyc=%0d, want addr=%0d", q[0].cyc, q[0].addr);
                    void'(q.pop_front());
                end
            end
        end
    end

    // Stimulus
    initial begin
        int en;
        rst_n            = 1'b0;
        bus.enable       = 1'b0;
        bus.fw           = 7'd0;
        bus.freq_control = 3'd0;
        bus.mirror_x     = 1'b0;
        bus.mirror_y     = 1'b0;
        cycle();
        cycle();
        check_idle("reset_state");
        rst_n = 1'b1;

        // Fastest rate, no folding, then fully folded waveform.
        setup(0, 127, 0, 0);
        repeat (40) cycle();
        setup(0, 127, 1, 1);
        repeat (80) cycle();
        setup(0, 127, 0, 1);
        repeat (70) cycle();
        setup(0, 127, 1, 0);
        repeat (70) cycle();

        // Reserved prescaler code behaves like divide-by-2.
        setup(7, 255, 0, 0);
        repeat (30) cycle();

        // Mid-period frequency change.
        setup(0, 127, 0, 0);
        repeat (21) cycle();
        bus.fw = 7'd63;
        repeat (60) cycle();

        // Divide-by-10 through a whole 1024-tick period, and a few divide-by-1000 ticks.
        setup(1, 0, 0, 0);
        repeat (10300) cycle();
        setup(3, 100, 1, 0);
        repeat (3100) cycle();

        // One-cycle reset in the middle of a period with enable held high.
        setup(0, 127, 1, 1);
        repeat (25) cycle();
        rst_n = 1'b0;
        cycle();
        check_idle("mid_run_reset");
        rst_n = 1'b1;
        repeat (40) cycle();

        // Randomized runs with mid-run control changes and enable gaps.
        for (int r = 0; r < 12; r++) begin
            int fsel;
            fsel = $urandom_range(0, 3);
            setup((fsel == 3) ? 7 : fsel, $urandom_range(0, 127), $urandom_range(0, 1), $urandom_range(0, 1));
            en = 1;
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 29) == 0) bus.fw = 7'($urandom_range(0, 127));
                if ($urandom_range(0, 59) == 0) bus.mirror_x = ~bus.mirror_x;
                if ($urandom_range(0, 59) == 0) bus.mirror_y = ~bus.mirror_y;
                if ($urandom_range(0, 119) == 0) bus.freq_control = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7;
                if ($urandom_range(0, 39) == 0) en = 1 - en;
                bus.enable = en[0];
                cycle();
            end
        end

        bus.enable = 1'b0;
        repeat (4) cycle();
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected: got %0d unmatched, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
